// File: rtl/idex_dbg_pkg.sv
// Shared definitions for the ID/EX debug snapshot reader: FSM states,
// frame geometry, snapshot layout and a word byte-select helper.
package idex_dbg_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_CHECKSUM
    } state_t;

    localparam logic [4:0] FRAME_LEN     = 5'd27;
    localparam logic [4:0] PAYLOAD_FIRST = 5'd1;
    localparam logic [4:0] PAYLOAD_LAST  = 5'd25;
    localparam logic [4:0] CHK_IDX       = 5'd26;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    typedef struct packed {
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic [31:0] sig_extended;
        logic [31:0] rs_reg;
        logic [31:0] rt_reg;
        logic [31:0] pc;
        logic [31:0] jump_address;
        logic [5:0]  op;
        logic        reg_dst;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        shmat;
        logic [2:0]  ls_type;
    } snap_t;

    localparam int unsigned SNAP_W = $bits(snap_t);

    // k=0 selects the most significant byte (big-endian streaming order).
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        return w[8*(3-k) +: 8];
    endfunction

endpackage

// File: rtl/idex_snapshot_reg.sv
// Load-enable register bank holding one frozen copy of a pipeline register.
module idex_snapshot_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/idex_snapshot_reader.sv
// Freezes the ID/EX register outputs on request and streams them as a
// 27-byte header/payload/checksum frame over a valid/ready byte port.
module idex_snapshot_reader
    import idex_dbg_pkg::*;
#(
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [4:0]  i_rt_addr,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_sig_extended,
    input  logic [31:0] i_rs_reg,
    input  logic [31:0] i_rt_reg,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_jump_address,
    input  logic [5:0]  i_op,
    input  logic        is_RegDst,
    input  logic        is_MemRead,
    input  logic        is_MemWrite,
    input  logic        is_MemtoReg,
    input  logic        is_ALUsrc,
    input  logic        is_RegWrite,
    input  logic        is_shmat,
    input  logic [3:0]  is_ALUop,
    input  logic [2:0]  is_load_store_type,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_done
);

    state_t      state_q;
    logic [4:0]  idx_q;
    logic [7:0]  chk_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        busy_q;
    logic        done_q;

    snap_t       snap_d;
    snap_t       snap_q;
    logic        capture;
    logic        hs;
    logic [4:0]  idx_nxt;
    logic [7:0]  chk_nxt;

    always_comb begin
        snap_d              = '0;
        snap_d.rt_addr      = i_rt_addr;
        snap_d.rd_addr      = i_rd_addr;
        snap_d.sig_extended = i_sig_extended;
        snap_d.rs_reg       = i_rs_reg;
        snap_d.rt_reg       = i_rt_reg;
        snap_d.pc           = i_pc;
        snap_d.jump_address = i_jump_address;
        snap_d.op           = i_op;
        snap_d.reg_dst      = is_RegDst;
        snap_d.mem_read     = is_MemRead;
        snap_d.mem_write    = is_MemWrite;
        snap_d.mem_to_reg   = is_MemtoReg;
        snap_d.alu_op       = is_ALUop;
        snap_d.alu_src      = is_ALUsrc;
        snap_d.reg_write    = is_RegWrite;
        snap_d.shmat        = is_shmat;
        snap_d.ls_type      = is_load_store_type;
    end

    assign capture = (state_q == S_IDLE) && i_start;

    logic [SNAP_W-1:0] snap_bits_q;

    idex_snapshot_reg #(
        .W (SNAP_W)
    ) u_snap (
        .clk    (clk),
        .rst    (rst),
        .load_i (capture),
        .d_i    (snap_d),
        .q_o    (snap_bits_q)
    );

    assign snap_q = snap_t'(snap_bits_q);

    // Payload byte for frame indices 1..25; anything else reads as zero.
    function automatic logic [7:0] payload_byte(input snap_t s, input logic [4:0] idx);
        logic [4:0]  off;
        logic [31:0] w;
        logic [7:0]  b;
        off = idx - PAYLOAD_FIRST;
        w   = '0;
        b   = '0;
        if (idx >= PAYLOAD_FIRST && idx <= 5'd20) begin
            case (off[4:2])
                3'd0:    w = s.sig_extended;
                3'd1:    w = s.rs_reg;
                3'd2:    w = s.rt_reg;
                3'd3:    w = s.pc;
                default: w = s.jump_address;
            endcase
            b = word_byte(w, off[1:0]);
        end else begin
            case (idx)
                5'd21:   b = {3'b000, s.rt_addr};
                5'd22:   b = {3'b000, s.rd_addr};
                5'd23:   b = {2'b00, s.op};
                5'd24:   b = {s.reg_dst, s.mem_read, s.mem_write, s.mem_to_reg, s.alu_op};
                5'd25:   b = {2'b00, s.alu_src, s.reg_write, s.shmat, s.ls_type};
                default: b = '0;
            endcase
        end
        return b;
    endfunction

    assign hs      = tx_valid_q && i_tx_ready;
    assign idx_nxt = idx_q + 5'd1;
    assign chk_nxt = chk_q ^ tx_data_q;

    // The output byte is registered, so each handshake preloads the byte for
    // the next index; the checksum byte folds in the last payload byte directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            chk_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q    <= S_HEADER;
                        idx_q      <= '0;
                        chk_q      <= '0;
                        tx_data_q  <= HEADER;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_HEADER: begin
                    if (hs) begin
                        state_q   <= S_PAYLOAD;
                        idx_q     <= idx_nxt;
                        tx_data_q <= payload_byte(snap_q, idx_nxt);
                    end
                end
                S_PAYLOAD: begin
                    if (hs) begin
                        idx_q <= idx_nxt;
                        chk_q <= chk_nxt;
                        if (idx_q == PAYLOAD_LAST) begin
                            state_q   <= S_CHECKSUM;
                            tx_data_q <= chk_nxt;
                        end else begin
                            tx_data_q <= payload_byte(snap_q, idx_nxt);
                        end
                    end
                end
                S_CHECKSUM: begin
                    if (hs) begin
                        state_q    <= S_IDLE;
                        idx_q      <= '0;
                        chk_q      <= '0;
                        tx_data_q  <= '0;
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_idex_snapshot_reader.sv
// Self-checking bench: directed and randomized frames compared against a
// byte-array frame model, with backpressure, disturbance and reset cases.
module tb_idex_snapshot_reader;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [4:0]  i_rt_addr;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_sig_extended;
    logic [31:0] i_rs_reg;
    logic [31:0] i_rt_reg;
    logic [31:0] i_pc;
    logic [31:0] i_jump_address;
    logic [5:0]  i_op;
    logic        is_RegDst, is_MemRead, is_MemWrite, is_MemtoReg;
    logic        is_ALUsrc, is_RegWrite, is_shmat;
    logic [3:0]  is_ALUop;
    logic [2:0]  is_load_store_type;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_done;

    int total;
    int bad;

    logic [7:0] exp_b [27];
    logic [7:0] got_b [27];
    int         got_n;
    bit         lat_ok;
    bit         done_ok;
    int         errs;
    bit         timeout;

    idex_snapshot_reader dut (
        .clk                (clk),
        .rst                (rst),
        .i_start            (i_start),
        .i_rt_addr          (i_rt_addr),
        .i_rd_addr          (i_rd_addr),
        .i_sig_extended     (i_sig_extended),
        .i_rs_reg           (i_rs_reg),
        .i_rt_reg           (i_rt_reg),
        .i_pc               (i_pc),
        .i_jump_address     (i_jump_address),
        .i_op               (i_op),
        .is_RegDst          (is_RegDst),
        .is_MemRead         (is_MemRead),
        .is_MemWrite        (is_MemWrite),
        .is_MemtoReg        (is_MemtoReg),
        .is_ALUsrc          (is_ALUsrc),
        .is_RegWrite        (is_RegWrite),
        .is_shmat           (is_shmat),
        .is_ALUop           (is_ALUop),
        .is_load_store_type (is_load_store_type),
        .o_tx_data          (o_tx_data),
        .o_tx_valid         (o_tx_valid),
        .i_tx_ready         (i_tx_ready),
        .o_busy             (o_busy),
        .o_done             (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_fields();
        i_rt_addr = '0; i_rd_addr = '0; i_sig_extended = '0; i_rs_reg = '0;
        i_rt_reg = '0; i_pc = '0; i_jump_address = '0; i_op = '0;
        is_RegDst = 0; is_MemRead = 0; is_MemWrite = 0; is_MemtoReg = 0;
        is_ALUsrc = 0; is_RegWrite = 0; is_shmat = 0;
        is_ALUop = '0; is_load_store_type = '0;
    endtask

    task automatic random_fields();
        i_rt_addr = 5'($urandom); i_rd_addr = 5'($urandom);
        i_sig_extended = $urandom; i_rs_reg = $urandom; i_rt_reg = $urandom;
        i_pc = $urandom; i_jump_address = $urandom; i_op = 6'($urandom);
        {is_RegDst, is_MemRead, is_MemWrite, is_MemtoReg} = 4'($urandom);
        {is_ALUsrc, is_RegWrite, is_shmat} = 3'($urandom);
        is_ALUop = 4'($urandom); is_load_store_type = 3'($urandom);
    endtask

    // Reference frame straight from the field list: header, five big-endian
    // words, five packed bytes, then the XOR of everything but the header.
    task automatic build_exp();
        logic [31:0] w [5];
        logic [7:0]  x;
        w[0] = i_sig_extended; w[1] = i_rs_reg; w[2] = i_rt_reg;
        w[3] = i_pc; w[4] = i_jump_address;
        exp_b[0] = 8'hA5;
        for (int k = 0; k < 5; k++)
            for (int b = 0; b < 4; b++)
                exp_b[1 + 4*k + b] = 8'((w[k] >> (24 - 8*b)) & 32'hFF);
        exp_b[21] = {3'b000, i_rt_addr};
        exp_b[22] = {3'b000, i_rd_addr};
        exp_b[23] = {2'b00, i_op};
        exp_b[24] = {is_RegDst, is_MemRead, is_MemWrite, is_MemtoReg, is_ALUop};
        exp_b[25] = {2'b00, is_ALUsrc, is_RegWrite, is_shmat, is_load_store_type};
        x = 8'h00;
        for (int i = 1; i <= 25; i++) x = x ^ exp_b[i];
        exp_b[26] = x;
    endtask

    // Drives one start and collects accepted bytes; mode 0 ready=1,
    // mode 1 ready pattern 1-0-0-1, mode 2 random. disturb scrambles inputs
    // and pulses start mid-frame.
    task automatic capture(input int mode, input bit disturb);
        bit         rdy;
        bit         held_v;
        logic [7:0] held_d;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        lat_ok  = (o_tx_valid === 1'b1) && (o_tx_data === 8'hA5) && (o_busy === 1'b1);
        got_n   = 0;
        errs    = 0;
        timeout = 1'b1;
        done_ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 4 == 0) || (c % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_tx_ready = rdy;
            held_v = o_tx_valid && !rdy;
            held_d = o_tx_data;
            if (o_tx_valid === 1'b1 && rdy) begin
                if (got_n < 27) got_b[got_n] = o_tx_data;
                got_n++;
            end
            if (disturb && c >= 3 && c <= 8) begin
                random_fields();
                i_start = (c == 5 || c == 6);
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk); #1;
            if (held_v && (o_tx_valid !== 1'b1 || o_tx_data !== held_d)) errs++;
            if (got_n >= 27) begin
                done_ok = (o_done === 1'b1) && (o_busy === 1'b0) && (o_tx_valid === 1'b0);
                timeout = 1'b0;
                break;
            end
            if (o_done === 1'b1 || o_busy !== 1'b1) errs++;
        end
        i_start    = 1'b0;
        i_tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_start = 1'b0; i_tx_ready = 1'b0; clear_fields();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({o_tx_data, o_tx_valid, o_busy, o_done} !== 11'h0) begin
            bad++;
            $display("FAIL reset_outputs: got data=%h v=%b busy=%b done=%b, want all 0",
                     o_tx_data, o_tx_valid, o_busy, o_done);
        end
        rst = 1'b1; i_tx_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if (o_tx_valid !== 1'b0 || o_busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_ready: cycle %0d valid=%b busy=%b, want 0 0", c, o_tx_valid, o_busy);
            end
        end
        i_tx_ready = 1'b0;
    endtask

    task automatic test_pc_frame();
        clear_fields(); i_pc = 32'h0000_0004;
        build_exp();
        capture(0, 1'b0);
        total++;
        if (!lat_ok || timeout || errs != 0 || !done_ok || got_n != 27) begin
            bad++;
            $display("FAIL pc_frame_ctrl: lat=%b to=%b errs=%0d done=%b n=%0d, want 1 0 0 1 27",
                     lat_ok, timeout, errs, done_ok, got_n);
        end
        for (int i = 0; i < 27; i++) begin
            total++;
            if (got_b[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL pc_frame byte%0d: got %h want %h", i, got_b[i], exp_b[i]);
            end
        end
        total++;
        if (got_b[26] !== 8'h04 || got_b[16] !== 8'h04) begin
            bad++;
            $display("FAIL pc_frame_chk: got b16=%h b26=%h want 04 04", got_b[16], got_b[26]);
        end
    endtask

    task automatic test_sig_frame();
        clear_fields(); i_sig_extended = 32'h1234_5678;
        build_exp();
        capture(0, 1'b0);
        total++;
        if (timeout || !done_ok || {got_b[1], got_b[2], got_b[3], got_b[4]} !== 32'h12345678
            || got_b[26] !== 8'h08) begin
            bad++;
            $display("FAIL sig_frame: to=%b done=%b b1-4=%h%h%h%h chk=%h want 12345678 chk 08",
                     timeout, done_ok, got_b[1], got_b[2], got_b[3], got_b[4], got_b[26]);
        end
    endtask

    task automatic test_controls();
        clear_fields();
        is_RegDst = 1'b1; is_ALUop = 4'hA; is_ALUsrc = 1'b1; is_load_store_type = 3'b101;
        build_exp();
        capture(0, 1'b0);
        total++;
        if (timeout || got_b[24] !== 8'h8A || got_b[25] !== 8'h25 || got_b[26] !== 8'hAF) begin
            bad++;
            $display("FAIL controls: to=%b b24=%h b25=%h chk=%h want 8a 25 af",
                     timeout, got_b[24], got_b[25], got_b[26]);
        end
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 4; r++) begin
            random_fields();
            build_exp();
            capture((r == 0) ? 1 : 2, 1'b0);
            total++;
            if (timeout || errs != 0 || !done_ok || got_n != 27) begin
                bad++;
                $display("FAIL bp_ctrl run%0d: to=%b hold_errs=%0d done=%b n=%0d, want 0 0 1 27",
                         r, timeout, errs, done_ok, got_n);
            end
            for (int i = 0; i < 27; i++) begin
                total++;
                if (got_b[i] !== exp_b[i]) begin
                    bad++;
                    $display("FAIL bp run%0d byte%0d: got %h want %h", r, i, got_b[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_disturb();
        random_fields();
        build_exp();
        capture(2, 1'b1);
        total++;
        if (timeout || errs != 0 || !done_ok) begin
            bad++;
            $display("FAIL disturb_ctrl: to=%b errs=%0d done=%b, want 0 0 1", timeout, errs, done_ok);
        end
        for (int i = 0; i < 27; i++) begin
            total++;
            if (got_b[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL disturb byte%0d: got %h want %h", i, got_b[i], exp_b[i]);
            end
        end
        i_tx_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            total++;
            if (o_tx_valid !== 1'b0 || o_busy !== 1'b0) begin
                bad++;
                $display("FAIL no_second_frame: cycle %0d valid=%b busy=%b want 0 0", c, o_tx_valid, o_busy);
            end
        end
        i_tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            random_fields();
            build_exp();
            capture(0, 1'b0);
            total++;
            if (!lat_ok || timeout || !done_ok) begin
                bad++;
                $display("FAIL b2b frame%0d: lat=%b to=%b done=%b want 1 0 1", f, lat_ok, timeout, done_ok);
            end
            for (int i = 0; i < 27; i++) begin
                total++;
                if (got_b[i] !== exp_b[i]) begin
                    bad++;
                    $display("FAIL b2b frame%0d byte%0d: got %h want %h", f, i, got_b[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        bit reached;
        random_fields();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_tx_ready = 1'b1;
        acc = 0;
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (acc == 10) begin reached = 1'b1; break; end
            if (o_tx_valid === 1'b1) acc++;
            @(posedge clk); #1;
        end
        total++;
        if (!reached) begin
            bad++;
            $display("FAIL rst_mid_reach: accepted %0d bytes, want 10", acc);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({o_tx_data, o_tx_valid, o_busy, o_done} !== 11'h0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got data=%h v=%b busy=%b done=%b want all 0",
                     o_tx_data, o_tx_valid, o_busy, o_done);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (o_tx_valid !== 1'b0 || o_done !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_quiet: cycle %0d valid=%b done=%b want 0 0", c, o_tx_valid, o_done);
            end
        end
        random_fields();
        build_exp();
        capture(0, 1'b0);
        total++;
        if (!lat_ok || timeout || !done_ok) begin
            bad++;
            $display("FAIL rst_mid_fresh: lat=%b to=%b done=%b want 1 0 1", lat_ok, timeout, done_ok);
        end
        for (int i = 0; i < 27; i++) begin
            total++;
            if (got_b[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL rst_mid_fresh byte%0d: got %h want %h", i, got_b[i], exp_b[i]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_pc_frame();
        test_sig_frame();
        test_controls();
        test_backpressure();
        test_disturb();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idex_snapshot_reader.md
# idex_snapshot_reader

Debug-side reader for the ID/EX pipeline register. On a start request it freezes one copy of every ID/EX output field and streams it as a fixed 27-byte frame to the debug UART transmitter. The byte interface is valid/ready. The block sits between the ID/EX latch outputs and the UART TX byte input in the debug unit.

## Interface
- HEADER, 8'hA5, first byte of every frame
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-low
- i_start  in  1  request a snapshot; honoured only in IDLE
- i_rt_addr  in  5  ID/EX rt address
- i_rd_addr  in  5  ID/EX rd address
- i_sig_extended  in  32  sign-extended immediate
- i_rs_reg  in  32  rs register value
- i_rt_reg  in  32  rt register value
- i_pc  in  32  PC
- i_jump_address  in  32  jump target
- i_op  in  6  opcode
- is_RegDst, is_MemRead, is_MemWrite, is_MemtoReg, is_ALUsrc, is_RegWrite, is_shmat  in  1 each  control flags
- is_ALUop  in  4  ALU op
- is_load_store_type  in  3  load/store type
- o_tx_data  out  8  frame byte
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  transmitter accepts byte
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse after the last byte is accepted

## Operation
- States:
  - IDLE: waiting for i_start.
  - HEADER: sending byte 0.
  - PAYLOAD: sending bytes 1..25.
  - CHECKSUM: sending byte 26.
- Capture: in IDLE with i_start=1, all inputs are registered into a snapshot and the state moves to HEADER. Later changes on the inputs do not affect the frame.
- Frame layout (index: content):
  - 0: HEADER.
  - 1-4: sig_extended.
  - 5-8: rs_reg.
  - 9-12: rt_reg.
  - 13-16: pc.
  - 17-20: jump_address.
  - 21: {3'b0, rt_addr}.
  - 22: {3'b0, rd_addr}.
  - 23: {2'b0, op}.
  - 24: {RegDst, MemRead, MemWrite, MemtoReg, ALUop[3:0]}.
  - 25: {2'b0, ALUsrc, RegWrite, shmat, load_store_type[2:0]}.
  - 26: checksum.
- Word byte order: MSB first (big-endian).
- Checksum: XOR of bytes 1..25. The header is excluded. It is accumulated as payload bytes are accepted.
- Byte index counter: 5 bits, range 0..26. It advances only on the handshake o_tx_valid & i_tx_ready at a clock edge.
- Transitions:
  - HEADER → PAYLOAD on handshake.
  - PAYLOAD → CHECKSUM on handshake of index 25.
  - CHECKSUM → IDLE on handshake, with o_done=1 for the following cycle.
- i_start outside IDLE is ignored. It is not queued.
- o_tx_data and o_tx_valid stay stable while o_tx_valid=1 and i_tx_ready=0.

## Timing
- Reset values:
  - o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0.
  - State IDLE.
  - Snapshot, counter and checksum all 0.
- Start latency: i_start sampled at edge N → o_tx_valid=1 with 0xA5 and o_busy=1 from cycle N+1.
- Handshake throughput: one byte per cycle. With i_tx_ready held high, a frame occupies exactly 27 cycles of o_tx_valid=1.
- Completion:
  - The cycle after the final handshake has o_done=1, o_busy=0, o_tx_valid=0.
  - A new i_start in that same cycle is accepted, so back-to-back frames have one idle cycle between them.
- o_tx_valid is registered. It does not depend combinationally on i_tx_ready.
- Reset mid-frame: the frame is aborted and all outputs take their reset values at the next edge. No partial checksum is emitted.
- i_tx_ready high while o_tx_valid=0: no effect.

## Structure
- Shared package idex_dbg_pkg holds:
  - The state enum.
  - FRAME_LEN=27, PAYLOAD_FIRST=1, PAYLOAD_LAST=25, CHK_IDX=26.
  - The default header value.
- Byte selection is a combinational mux on the index over the snapshot, inside this module. No sub-module is required.
- The snapshot register may be split into a small sub-module, idex_snapshot_reg (load-enable register bank), if reuse for the EX/MEM reader is wanted.

## Test plan
- Reset then idle: rst=0 for 2 cycles → all outputs 0. i_tx_ready=1 with no start → o_tx_valid stays 0.
- pc=0x00000004, all other fields 0, ready=1, start → bytes A5, 0×12, 00 00 00 04, 0×9, checksum 04. o_done one cycle after the 27th byte.
- sig_extended=0x12345678, all other fields 0 → bytes 1-4 = 12 34 56 78, checksum 08.
- Controls: RegDst=1, ALUop=4'hA, ALUsrc=1, lst=3'b101, other fields 0 → byte24=0x8A, byte25=0x25, checksum 0xAF.
- Backpressure: i_tx_ready toggles 1-0-0-1 → each byte held unchanged while ready=0. Bytes are neither skipped nor duplicated, and the frame matches the ready=1 case.
- Inputs change and i_start is pulsed during a frame → frame content unchanged, no second frame. rst=0 at byte 10 → o_tx_valid=0 next cycle, and a new start yields a full fresh frame.
